cop_ise_arb2: RTL and testbench

//  Shares one combinational Xoodyak ISE co-processor (cop_ise) between two requesting cores/harts.

---
 rtl/cop_ise_pkg.sv | 25 ++
 rtl/cop_rr_arb2.sv | 23 ++
 rtl/cop_ise_arb2.sv | 160 ++++++++++++++++
 tb/tb_cop_ise_arb2.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cop_ise_pkg.sv
// Shared constants and types for the two-requester Xoodyak ISE arbiter (cop_ise_arb2).
package cop_ise_pkg;

    localparam int COP_XLEN = 64;

    // RISC-V custom opcode space used by the Xoodyak ISE
    localparam logic [6:0] CUSTOM_0 = 7'b0001011;
    localparam logic [6:0] CUSTOM_1 = 7'b0101011;
    localparam logic [6:0] CUSTOM_2 = 7'b1011011;
    localparam logic [6:0] CUSTOM_3 = 7'b1111011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } cop_state_e;

    typedef logic req_id_t;

    function automatic req_id_t gnt_to_id(input logic [1:0] gnt);
        return gnt[1] & ~gnt[0];
    endfunction

endpackage

// File: rtl/cop_rr_arb2.sv
// Two-way combinational arbiter producing a one-hot grant.
// Round-robin by default; COP_ARB_FIXED_PRIO_EN makes requester 0 always win and drops the pointer.
module cop_rr_arb2 (
    input  logic [1:0] i_req,
`ifndef COP_ARB_FIXED_PRIO_EN
    input  logic       i_ptr,
`endif
    output logic [1:0] o_gnt
);

`ifdef COP_ARB_FIXED_PRIO_EN
    assign o_gnt = {i_req[1] & ~i_req[0], i_req[0]};
`else
    // A lone requester always wins; on contention the pointer names the winner.
    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = i_ptr ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

// File: rtl/cop_ise_arb2.sv
// Shares one combinational Xoodyak ISE between two requesters: arbitrate, stage, issue, buffer, return.
// Optional COP_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
module cop_ise_arb2
    import cop_ise_pkg::*;
#(
    parameter int XLEN = COP_XLEN
) (
    input  logic            cop_clk,
    input  logic            cop_rst,

    input  logic            r0_valid,
    input  logic [31:0]     r0_insn,
    input  logic [XLEN-1:0] r0_rs1,
    input  logic [XLEN-1:0] r0_rs2,
    input  logic            r0_rdywr,
    output logic            r0_wr,
    output logic [XLEN-1:0] r0_rd,
    output logic            r0_ready,

    input  logic            r1_valid,
    input  logic [31:0]     r1_insn,
    input  logic [XLEN-1:0] r1_rs1,
    input  logic [XLEN-1:0] r1_rs2,
    input  logic            r1_rdywr,
    output logic            r1_wr,
    output logic [XLEN-1:0] r1_rd,
    output logic            r1_ready,

    output logic            ise_valid,
    output logic [31:0]     ise_insn,
    output logic [XLEN-1:0] ise_rs1,
    output logic [XLEN-1:0] ise_rs2,
    input  logic            ise_wr,
    input  logic [XLEN-1:0] ise_rd,
    output logic            ise_rdywr
);

    cop_state_e      r_state;
    cop_state_e      w_state_next;
    req_id_t         r_gnt;
    logic [31:0]     r_insn;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_res;

    logic [1:0]      w_req;
    logic [1:0]      w_gnt_oh;
    req_id_t         w_gnt_id;
    logic            w_rdywr_g;
    logic            w_wr;
    logic            w_ready;
    logic [XLEN-1:0] w_rd;

    assign w_req = {r1_valid, r0_valid};

`ifdef COP_ARB_FIXED_PRIO_EN
    cop_rr_arb2 u_arb (
        .i_req (w_req),
        .o_gnt (w_gnt_oh)
    );
`else
    logic r_ptr;

    cop_rr_arb2 u_arb (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt_oh)
    );

    // The pointer only moves on a completion pulse, handing priority to the other side.
    always_ff @(posedge cop_clk or negedge cop_rst) begin
        if (!cop_rst) begin
            r_ptr <= 1'b0;
        end else if (w_ready) begin
            r_ptr <= ~r_gnt;
        end
    end
`endif

    assign w_gnt_id  = gnt_to_id(w_gnt_oh);
    assign w_rdywr_g = r_gnt ? r1_rdywr : r0_rdywr;

    always_ff @(posedge cop_clk or negedge cop_rst) begin
        if (!cop_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge cop_clk or negedge cop_rst) begin
        if (!cop_rst) begin
            r_gnt  <= 1'b0;
            r_insn <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_res  <= '0;
        end else begin
            if (r_state == IDLE && (|w_req)) begin
                r_gnt  <= w_gnt_id;
                r_insn <= w_gnt_id ? r1_insn : r0_insn;
                r_rs1  <= w_gnt_id ? r1_rs1  : r0_rs1;
                r_rs2  <= w_gnt_id ? r1_rs2  : r0_rs2;
            end
            if (r_state == ISSUE) begin
                r_res <= ise_rd;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_state_next = ISSUE;
            ISSUE:   w_state_next = ise_wr ? RESP : DONE;
            RESP:    if (w_rdywr_g) w_state_next = IDLE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ise_valid = 1'b0;
        ise_insn  = '0;
        ise_rs1   = '0;
        ise_rs2   = '0;
        w_wr      = 1'b0;
        w_ready   = 1'b0;
        w_rd      = '0;
        case (r_state)
            ISSUE: begin
                ise_valid = 1'b1;
                ise_insn  = r_insn;
                ise_rs1   = r_rs1;
                ise_rs2   = r_rs2;
            end
            RESP: begin
                w_wr    = 1'b1;
                w_rd    = r_res;
                w_ready = w_rdywr_g;
            end
            DONE: begin
                w_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Only the granted requester ever sees a non-zero response.
    assign r0_wr    = w_wr    & ~r_gnt;
    assign r0_ready = w_ready & ~r_gnt;
    assign r0_rd    = r_gnt ? '0 : w_rd;
    assign r1_wr    = w_wr    & r_gnt;
    assign r1_ready = w_ready & r_gnt;
    assign r1_rd    = r_gnt ? w_rd : '0;

    assign ise_rdywr = 1'b1;

endmodule

// File: tb/tb_cop_ise_arb2.sv
// Self-checking bench for cop_ise_arb2 with a behavioural ISE stub and a timeline reference model.
module tb_cop_ise_arb2;
    import cop_ise_pkg::*;

    localparam int XLEN = 64;

    logic            cop_clk = 1'b0;
    logic            cop_rst = 1'b0;
    logic            r0_valid, r0_rdywr, r0_wr, r0_ready;
    logic            r1_valid, r1_rdywr, r1_wr, r1_ready;
    logic [31:0]     r0_insn, r1_insn, ise_insn;
    logic [XLEN-1:0] r0_rs1, r0_rs2, r0_rd, r1_rs1, r1_rs2, r1_rd;
    logic            ise_valid, ise_wr, ise_rdywr;
    logic [XLEN-1:0] ise_rs1, ise_rs2, ise_rd;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 cop_clk = ~cop_clk;

    cop_ise_arb2 #(.XLEN(XLEN)) dut (
        .cop_clk   (cop_clk),   .cop_rst   (cop_rst),
        .r0_valid  (r0_valid),  .r0_insn   (r0_insn),  .r0_rs1 (r0_rs1), .r0_rs2 (r0_rs2),
        .r0_rdywr  (r0_rdywr),  .r0_wr     (r0_wr),    .r0_rd  (r0_rd),  .r0_ready (r0_ready),
        .r1_valid  (r1_valid),  .r1_insn   (r1_insn),  .r1_rs1 (r1_rs1), .r1_rs2 (r1_rs2),
        .r1_rdywr  (r1_rdywr),  .r1_wr     (r1_wr),    .r1_rd  (r1_rd),  .r1_ready (r1_ready),
        .ise_valid (ise_valid), .ise_insn  (ise_insn), .ise_rs1 (ise_rs1), .ise_rs2 (ise_rs2),
        .ise_wr    (ise_wr),    .ise_rd    (ise_rd),   .ise_rdywr (ise_rdywr)
    );

    // ISE behaviour: CUSTOM_0 with funct7 0x01 = rotate-left rs1 by insn[24:20], 0x02 = rs1 & ~rs2
    function automatic logic ise_sup(input logic [31:0] insn);
        return (insn[6:0] == CUSTOM_0) && (insn[31:25] == 7'h01 || insn[31:25] == 7'h02);
    endfunction

    function automatic logic [XLEN-1:0] ise_calc(input logic [31:0] insn,
                                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] dbl;
        if (!ise_sup(insn)) return '0;
        if (insn[31:25] == 7'h01) begin
            dbl = {a, a} << insn[24:20];
            return dbl[2*XLEN-1:XLEN];
        end
        return a & ~b;
    endfunction

    assign ise_wr = ise_sup(ise_insn);
    assign ise_rd = ise_calc(ise_insn, ise_rs1, ise_rs2);

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] sh, input logic [6:0] op);
        return {f7, sh, 13'd0, op};
    endfunction

    function automatic logic [31:0] rand_insn();
        case ($urandom_range(3))
            0:       return mk(7'h01, 5'($urandom), CUSTOM_0);
            1:       return mk(7'h02, 5'd0, CUSTOM_0);
            2:       return mk(7'h7F, 5'($urandom), CUSTOM_0);
            default: return mk(7'($urandom), 5'($urandom), 7'h33);
        endcase
    endfunction

    task automatic idle_inputs();
        r0_valid = 1'b0; r0_insn = '0; r0_rs1 = '0; r0_rs2 = '0; r0_rdywr = 1'b0;
        r1_valid = 1'b0; r1_insn = '0; r1_rs1 = '0; r1_rs2 = '0; r1_rdywr = 1'b0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released: the drive point of cycle 0.
    task automatic apply_reset();
        cop_rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge cop_clk);
        #1 cop_rst = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge cop_clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        cop_rst = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1; r0_rdywr = 1'b1; r1_rdywr = 1'b1;
        r0_insn = mk(7'h02, 5'd0, CUSTOM_0); r1_insn = r0_insn;
        r0_rs1 = 64'hFF; r1_rs1 = 64'hFF;
        repeat (3) @(posedge cop_clk);
        @(negedge cop_clk);
        tests_run++; if ({r0_wr, r0_ready, r1_wr, r1_ready, ise_valid} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b expected 00000", {r0_wr, r0_ready, r1_wr, r1_ready, ise_valid}); end
        tests_run++; if ((r0_rd | r1_rd | ise_rs1 | ise_rs2) !== '0) begin
            tests_failed++; $display("FAIL reset_data: got %h expected 0", r0_rd | r1_rd | ise_rs1 | ise_rs2); end
        tests_run++; if (ise_insn !== 32'h0) begin
            tests_failed++; $display("FAIL reset_ise_insn: got %h expected 0", ise_insn); end
        tests_run++; if (ise_rdywr !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ise_rdywr: got %b expected 1", ise_rdywr); end
        apply_reset();
        @(negedge cop_clk);
        tests_run++; if ({r0_wr, r0_ready, r1_wr, r1_ready, ise_valid} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_idle: got %b expected 00000", {r0_wr, r0_ready, r1_wr, r1_ready, ise_valid}); end
    endtask

    task automatic test_single();
        logic [31:0] insn;
        apply_reset();
        insn = mk(7'h01, 5'd1, CUSTOM_0);
        r0_valid = 1'b1; r0_insn = insn; r0_rs1 = 64'h8000_0000_0000_0001; r0_rs2 = '0; r0_rdywr = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next_cycle();
            if (c == 3) r0_valid = 1'b0;
            @(negedge cop_clk);
            tests_run++; if (r0_ready !== (c == 2)) begin
                tests_failed++; $display("FAIL single_ready c%0d: got %b expected %b", c, r0_ready, c == 2); end
            tests_run++; if (ise_valid !== (c == 1)) begin
                tests_failed++; $display("FAIL single_ise_valid c%0d: got %b expected %b", c, ise_valid, c == 1); end
            tests_run++; if ({r1_wr, r1_ready, r1_rd} !== '0) begin
                tests_failed++; $display("FAIL single_r1_quiet c%0d: got %h expected 0", c, {r1_wr, r1_ready, r1_rd}); end
            if (c == 1) begin
                tests_run++; if (ise_insn !== insn || ise_rs1 !== 64'h8000_0000_0000_0001) begin
                    tests_failed++; $display("FAIL single_issue: got %h/%h expected %h/8000000000000001", ise_insn, ise_rs1, insn); end
            end
            if (c == 2) begin
                tests_run++; if (r0_wr !== 1'b1 || r0_rd !== 64'h3) begin
                    tests_failed++; $display("FAIL single_result: got wr=%b rd=%h expected wr=1 rd=3", r0_wr, r0_rd); end
            end
        end
    endtask

    task automatic test_both();
        apply_reset();
        r0_valid = 1'b1; r0_insn = mk(7'h02, 5'd0, CUSTOM_0); r0_rs1 = 64'hFF;   r0_rs2 = 64'h0F; r0_rdywr = 1'b1;
        r1_valid = 1'b1; r1_insn = r0_insn;                   r1_rs1 = 64'hF0F0; r1_rs2 = 64'hFF; r1_rdywr = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            if (c == 3) r0_valid = 1'b0;
            if (c == 6) r0_valid = 1'b1;
            if (c == 9) r0_valid = 1'b0;
            @(negedge cop_clk);
            tests_run++; if (r0_ready !== (c == 2 || c == 8)) begin
                tests_failed++; $display("FAIL both_r0_ready c%0d: got %b expected %b", c, r0_ready, c == 2 || c == 8); end
            tests_run++; if (r1_ready !== (c == 5)) begin
                tests_failed++; $display("FAIL both_r1_ready c%0d: got %b expected %b", c, r1_ready, c == 5); end
            if (c == 2 || c == 8) begin
                tests_run++; if (r0_rd !== 64'hF0) begin
                    tests_failed++; $display("FAIL both_r0_rd c%0d: got %h expected f0", c, r0_rd); end
            end
            if (c == 5) begin
                tests_run++; if (r1_rd !== 64'hF000) begin
                    tests_failed++; $display("FAIL both_r1_rd: got %h expected f000", r1_rd); end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        r1_valid = 1'b1; r1_insn = mk(7'h02, 5'd0, CUSTOM_0); r1_rs1 = 64'h1234_5678_9ABC_DEF0;
        r1_rs2 = 64'h0000_FFFF_0000_FFFF; r1_rdywr = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            if (c == 6) r1_rdywr = 1'b1;
            if (c == 7) r1_valid = 1'b0;
            @(negedge cop_clk);
            tests_run++; if (r1_ready !== (c == 6)) begin
                tests_failed++; $display("FAIL bp_ready c%0d: got %b expected %b", c, r1_ready, c == 6); end
            tests_run++; if (r1_wr !== (c >= 2 && c <= 6)) begin
                tests_failed++; $display("FAIL bp_wr c%0d: got %b expected %b", c, r1_wr, c >= 2 && c <= 6); end
            if (c >= 2 && c <= 6) begin
                tests_run++; if (r1_rd !== 64'h1234_0000_9ABC_0000) begin
                    tests_failed++; $display("FAIL bp_rd c%0d: got %h expected 123400009abc0000", c, r1_rd); end
            end
            tests_run++; if ({r0_wr, r0_ready, r0_rd} !== '0) begin
                tests_failed++; $display("FAIL bp_r0_quiet c%0d: got %h expected 0", c, {r0_wr, r0_ready, r0_rd}); end
        end
    endtask

    task automatic test_unsupported();
        apply_reset();
        r0_valid = 1'b1; r0_insn = mk(7'h01, 5'd1, 7'h33); r0_rs1 = 64'hDEAD; r0_rdywr = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next_cycle();
            if (c == 3) r0_valid = 1'b0;
            @(negedge cop_clk);
            tests_run++; if (r0_ready !== (c == 2)) begin
                tests_failed++; $display("FAIL unsup_ready c%0d: got %b expected %b", c, r0_ready, c == 2); end
            tests_run++; if (r0_wr !== 1'b0 || r0_rd !== '0) begin
                tests_failed++; $display("FAIL unsup_wr_rd c%0d: got wr=%b rd=%h expected 0/0", c, r0_wr, r0_rd); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        r0_valid = 1'b1; r0_insn = mk(7'h02, 5'd0, CUSTOM_0); r0_rs1 = 64'hFF;   r0_rs2 = 64'h0F; r0_rdywr = 1'b0;
        r1_valid = 1'b1; r1_insn = r0_insn;                   r1_rs1 = 64'hF0F0; r1_rs2 = 64'hFF; r1_rdywr = 1'b1;
        @(negedge cop_clk);
        next_cycle(); @(negedge cop_clk);
        next_cycle(); @(negedge cop_clk);
        tests_run++; if (r0_wr !== 1'b1 || r0_ready !== 1'b0) begin
            tests_failed++; $display("FAIL rmid_resp: got wr=%b ready=%b expected 1/0", r0_wr, r0_ready); end
        next_cycle();
        cop_rst = 1'b0; r0_valid = 1'b0;
        #1;
        tests_run++; if ({r0_wr, r0_ready, r1_wr, r1_ready, ise_valid} !== 5'b0 || (r0_rd | r1_rd) !== '0) begin
            tests_failed++; $display("FAIL rmid_async: got %b rd=%h expected 0", {r0_wr, r0_ready, r1_wr, r1_ready, ise_valid}, r0_rd | r1_rd); end
        tests_run++; if (ise_rdywr !== 1'b1) begin
            tests_failed++; $display("FAIL rmid_ise_rdywr: got %b expected 1", ise_rdywr); end
        @(posedge cop_clk);
        #1 cop_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) next_cycle();
            @(negedge cop_clk);
            tests_run++; if (r1_ready !== (c == 2)) begin
                tests_failed++; $display("FAIL rmid_r1_ready c%0d: got %b expected %b", c, r1_ready, c == 2); end
            tests_run++; if ({r0_wr, r0_ready} !== 2'b0) begin
                tests_failed++; $display("FAIL rmid_r0_quiet c%0d: got %b expected 00", c, {r0_wr, r0_ready}); end
        end
        tests_run++; if (r1_rd !== 64'hF000) begin
            tests_failed++; $display("FAIL rmid_r1_rd: got %h expected f000", r1_rd); end
    endtask

    // Both requesters re-request immediately after every completion: one completion every 3 cycles.
    task automatic test_back_to_back();
        logic [XLEN-1:0] a [2];
        logic [XLEN-1:0] b [2];
        logic [XLEN-1:0] got;
        int ew;
        apply_reset();
        for (int i = 0; i < 2; i++) begin a[i] = {$urandom, $urandom}; b[i] = {$urandom, $urandom}; end
        r0_insn = mk(7'h02, 5'd0, CUSTOM_0); r1_insn = r0_insn;
        r0_valid = 1'b1; r1_valid = 1'b1; r0_rdywr = 1'b1; r1_rdywr = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) next_cycle();
            r0_rs1 = a[0]; r0_rs2 = b[0]; r1_rs1 = a[1]; r1_rs2 = b[1];
            @(negedge cop_clk);
`ifdef COP_ARB_FIXED_PRIO_EN
            ew = 0;
`else
            ew = (c / 3) % 2;
`endif
            tests_run++; if (r0_ready !== (c % 3 == 2 && ew == 0)) begin
                tests_failed++; $display("FAIL b2b_r0_ready c%0d: got %b expected %b", c, r0_ready, c % 3 == 2 && ew == 0); end
            tests_run++; if (r1_ready !== (c % 3 == 2 && ew == 1)) begin
                tests_failed++; $display("FAIL b2b_r1_ready c%0d: got %b expected %b", c, r1_ready, c % 3 == 2 && ew == 1); end
            if (c % 3 == 2) begin
                got = (ew == 1) ? r1_rd : r0_rd;
                tests_run++; if (got !== (a[ew] & ~b[ew])) begin
                    tests_failed++; $display("FAIL b2b_rd c%0d: got %h expected %h", c, got, a[ew] & ~b[ew]); end
                a[ew] = {$urandom, $urandom};
                b[ew] = {$urandom, $urandom};
            end
        end
    endtask

    // Randomised traffic against a timeline model: grant when idle, result two cycles after grant.
    task automatic test_random();
        logic [1:0]      pend, rdy, e_wr, e_rdy;
        logic [31:0]     insn [2];
        logic [XLEN-1:0] a [2];
        logic [XLEN-1:0] b [2];
        logic [XLEN-1:0] e_rd [2];
        logic [XLEN-1:0] exp_res;
        logic            busy, exp_sup, e_isev;
        int              g, w, prefer;
        apply_reset();
        pend = 2'b00; busy = 1'b0; g = 0; w = 0; prefer = 0; exp_res = '0; exp_sup = 1'b0;
        for (int i = 0; i < 2; i++) begin insn[i] = '0; a[i] = '0; b[i] = '0; end
        for (int c = 0; c < 800; c++) begin
            if (c > 0) next_cycle();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    insn[i] = rand_insn();
                    a[i] = {$urandom, $urandom};
                    b[i] = {$urandom, $urandom};
                end
                rdy[i] = ($urandom_range(3) != 0);
            end
            r0_valid = pend[0]; r0_insn = insn[0]; r0_rs1 = a[0]; r0_rs2 = b[0]; r0_rdywr = rdy[0];
            r1_valid = pend[1]; r1_insn = insn[1]; r1_rs1 = a[1]; r1_rs2 = b[1]; r1_rdywr = rdy[1];
            @(negedge cop_clk);
            if (!busy && pend != 2'b00) begin
                w = (pend == 2'b11) ? prefer : (pend[1] ? 1 : 0);
                busy = 1'b1; g = c;
                exp_sup = ise_sup(insn[w]);
                exp_res = ise_calc(insn[w], a[w], b[w]);
            end
            e_wr = 2'b00; e_rdy = 2'b00; e_rd[0] = '0; e_rd[1] = '0;
            if (busy && c >= g + 2) begin
                e_wr[w]  = exp_sup;
                e_rdy[w] = exp_sup ? rdy[w] : 1'b1;
                e_rd[w]  = exp_sup ? exp_res : '0;
            end
            e_isev = busy && (c == g + 1);
            tests_run++; if ({r1_ready, r0_ready} !== e_rdy) begin
                tests_failed++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, {r1_ready, r0_ready}, e_rdy); end
            tests_run++; if ({r1_wr, r0_wr} !== e_wr) begin
                tests_failed++; $display("FAIL rnd_wr c%0d: got %b expected %b", c, {r1_wr, r0_wr}, e_wr); end
            tests_run++; if (r0_rd !== e_rd[0] || r1_rd !== e_rd[1]) begin
                tests_failed++; $display("FAIL rnd_rd c%0d: got %h/%h expected %h/%h", c, r0_rd, r1_rd, e_rd[0], e_rd[1]); end
            tests_run++; if (ise_valid !== e_isev) begin
                tests_failed++; $display("FAIL rnd_ise_valid c%0d: got %b expected %b", c, ise_valid, e_isev); end
            if (e_isev) begin
                tests_run++; if (ise_insn !== insn[w] || ise_rs1 !== a[w] || ise_rs2 !== b[w]) begin
                    tests_failed++; $display("FAIL rnd_ise_ops c%0d: got %h/%h/%h expected %h/%h/%h", c, ise_insn, ise_rs1, ise_rs2, insn[w], a[w], b[w]); end
            end else begin
                tests_run++; if (ise_insn !== 32'h0 || ise_rs1 !== '0) begin
                    tests_failed++; $display("FAIL rnd_ise_idle c%0d: got %h/%h expected 0/0", c, ise_insn, ise_rs1); end
            end
            if (busy && e_rdy[w]) begin
                busy = 1'b0;
                pend[w] = 1'b0;
`ifdef COP_ARB_FIXED_PRIO_EN
                prefer = 0;
`else
                prefer = (w == 0) ? 1 : 0;
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_backpressure();
        test_unsupported();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
